// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg: AXI burst types plus beat address/strobe/legality helpers.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package axi_pkg;

  // Helpers work at the widest supported geometry; callers truncate.
  localparam int MAX_ADDR_W = 128;
  localparam int MAX_STRB_W = 128;

  typedef logic [7:0]            len_t;
  typedef logic [2:0]            size_t;
  typedef logic [1:0]            burst_t;
  typedef logic [MAX_ADDR_W-1:0] addr_t;
  typedef logic [MAX_STRB_W-1:0] strb_t;

  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;
  localparam burst_t BURST_WRAP  = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  function automatic addr_t size_bytes(size_t size);
    return addr_t'(1) << size;
  endfunction

  function automatic addr_t align_addr(addr_t addr, size_t size);
    return addr & ~(size_bytes(size) - addr_t'(1));
  endfunction

  function automatic addr_t wrap_total(size_t size, len_t len);
    return (addr_t'(len) + addr_t'(1)) << size;
  endfunction

  // Only meaningful for legal WRAP bursts, where the total is a power of two.
  function automatic addr_t wrap_boundary(addr_t addr, size_t size, len_t len);
    return addr & ~(wrap_total(size, len) - addr_t'(1));
  endfunction

  function automatic addr_t next_beat_addr(addr_t addr, size_t size, len_t len, burst_t burst);
    addr_t nxt;
    case (burst)
      BURST_FIXED: nxt = addr;
      BURST_WRAP:  nxt = wrap_boundary(addr, size, len) |
                         ((addr + size_bytes(size)) & (wrap_total(size, len) - addr_t'(1)));
      default:     nxt = align_addr(addr, size) + size_bytes(size);
    endcase
    return nxt;
  endfunction

  // First beat starts at the unaligned offset and ends at the aligned container end.
  function automatic strb_t beat_strb(addr_t addr, size_t size, logic first, int strb_width);
    int         lo;
    int         hi;
    int         nbytes;
    logic [6:0] al_lo;
    strb_t      s;
    nbytes = 1 << size;
    al_lo  = addr[6:0] & ~7'(nbytes - 1);
    lo     = int'(addr[6:0]) & (strb_width - 1);
    if (first) hi = (int'(al_lo) & (strb_width - 1)) + nbytes - 1;
    else       hi = lo + nbytes - 1;
    s = '0;
    for (int i = 0; i < MAX_STRB_W; i++) begin
      if (i >= lo && i <= hi && i < strb_width) s[i] = 1'b1;
    end
    return s;
  endfunction

  function automatic logic burst_legal(addr_t addr, len_t len, size_t size, burst_t burst,
                                       int strb_width);
    logic  ok;
    addr_t last_byte;
    ok        = 1'b1;
    last_byte = '0;
    if ((1 << size) > strb_width) ok = 1'b0;
    case (burst)
      BURST_FIXED: if (len > 8'd15) ok = 1'b0;
      BURST_INCR: begin
        last_byte = align_addr(addr, size) + ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);
        if (last_byte[MAX_ADDR_W-1:12] != addr[MAX_ADDR_W-1:12]) ok = 1'b0;
      end
      BURST_WRAP: begin
        if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ok = 1'b0;
        if ((addr & (size_bytes(size) - addr_t'(1))) != '0) ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_burst_beat_gen.sv
// ---------------------------------------------------------------------------
// axi_burst_beat_gen: expands one AXI burst request into per-beat addr/strobe.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module axi_burst_beat_gen
  import axi_pkg::*;
#(
  parameter  int AddrWidth = 64,
  parameter  int DataWidth = 64,
  localparam int StrbWidth = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [7:0]           req_len_i,
  input  logic [2:0]           req_size_i,
  input  logic [1:0]           req_burst_i,
  output logic                 beat_valid_o,
  input  logic                 beat_ready_i,
  output logic [AddrWidth-1:0] beat_addr_o,
  output logic [StrbWidth-1:0] beat_strb_o,
  output logic [7:0]           beat_idx_o,
  output logic                 beat_last_o,
  output logic                 err_o
);

  state_t                 state,     state_n;
  logic [AddrWidth-1:0]   cur_addr,  addr_n;
  logic [StrbWidth-1:0]   cur_strb,  strb_n;
  len_t                   cur_idx,   idx_n;
  len_t                   cur_len,   len_n;
  size_t                  cur_size,  size_n;
  burst_t                 cur_burst, burst_n;
  logic                   cur_last,  last_n;
  logic                   err,       err_n;

  logic                   hs_last;
  logic                   accept;
  logic                   legal;
  logic [AddrWidth-1:0]   step_addr;

  assign beat_valid_o = (state == ST_BURST);
  assign hs_last      = beat_valid_o && cur_last && beat_ready_i;
  assign req_ready_o  = (state == ST_IDLE) || hs_last;
  assign accept       = req_valid_i && req_ready_o;

  assign legal     = burst_legal(addr_t'(req_addr_i), req_len_i, req_size_i, req_burst_i,
                                 StrbWidth);
  assign step_addr = AddrWidth'(next_beat_addr(addr_t'(cur_addr), cur_size, cur_len, cur_burst));

  assign beat_addr_o = cur_addr;
  assign beat_strb_o = cur_strb;
  assign beat_idx_o  = cur_idx;
  assign beat_last_o = cur_last;
  assign err_o       = err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      cur_addr  <= '0;
      cur_strb  <= '0;
      cur_idx   <= '0;
      cur_len   <= '0;
      cur_size  <= '0;
      cur_burst <= '0;
      cur_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cur_addr  <= addr_n;
      cur_strb  <= strb_n;
      cur_idx   <= idx_n;
      cur_len   <= len_n;
      cur_size  <= size_n;
      cur_burst <= burst_n;
      cur_last  <= last_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = cur_addr;
    strb_n  = cur_strb;
    idx_n   = cur_idx;
    len_n   = cur_len;
    size_n  = cur_size;
    burst_n = cur_burst;
    last_n  = cur_last;
    err_n   = 1'b0;

    if (state == ST_BURST && beat_ready_i) begin
      if (cur_last) begin
        state_n = ST_IDLE;
      end else begin
        addr_n = step_addr;
        strb_n = StrbWidth'(beat_strb(addr_t'(step_addr), cur_size, 1'b0, StrbWidth));
        idx_n  = cur_idx + 8'd1;
        last_n = ((cur_idx + 8'd1) == cur_len);
      end
    end

    // A request can only be taken in IDLE or on the last-beat handshake,
    // so it always overrides the end-of-burst return to IDLE above.
    if (accept) begin
      if (legal) begin
        state_n = ST_BURST;
        addr_n  = req_addr_i;
        strb_n  = StrbWidth'(beat_strb(addr_t'(req_addr_i), req_size_i, 1'b1, StrbWidth));
        idx_n   = '0;
        last_n  = (req_len_i == 8'd0);
        len_n   = req_len_i;
        size_n  = req_size_i;
        burst_n = req_burst_i;
      end else begin
        state_n = ST_IDLE;
        err_n   = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_burst_beat_gen.sv
// ---------------------------------------------------------------------------
// tb_axi_burst_beat_gen: directed vectors plus randomized bursts vs a model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axi_burst_beat_gen;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic [7:0]    req_len_i;
  logic [2:0]    req_size_i;
  logic [1:0]    req_burst_i;
  logic          beat_valid_o;
  logic          beat_ready_i;
  logic [AW-1:0] beat_addr_o;
  logic [SW-1:0] beat_strb_o;
  logic [7:0]    beat_idx_o;
  logic          beat_last_o;
  logic          err_o;

  always #5 clk = ~clk;

  axi_burst_beat_gen #(.AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_len_i    (req_len_i),
    .req_size_i   (req_size_i),
    .req_burst_i  (req_burst_i),
    .beat_valid_o (beat_valid_o),
    .beat_ready_i (beat_ready_i),
    .beat_addr_o  (beat_addr_o),
    .beat_strb_o  (beat_strb_o),
    .beat_idx_o   (beat_idx_o),
    .beat_last_o  (beat_last_o),
    .err_o        (err_o)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_addr [16];
  logic [7:0]  exp_strb [16];

  typedef struct {
    logic [63:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    bit               legal;
    logic [3:0][63:0] ea;
    logic [3:0][7:0]  es;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the address/strobe/legality rules in plain arithmetic.
  function automatic logic [63:0] model_addr(logic [63:0] a, logic [7:0] len, logic [2:0] size,
                                             logic [1:0] burst, int i);
    logic [63:0] step, total, bnd, x;
    step = 64'd1 << size;
    if (i == 0 || burst == 2'b00) return a;
    if (burst == 2'b01) return (a / step) * step + 64'(i) * step;
    total = step * (64'(len) + 64'd1);
    bnd   = (a / total) * total;
    x     = a + 64'(i) * step;
    if (x >= bnd + total) x = x - total;
    return x;
  endfunction

  function automatic logic [7:0] model_strb(logic [63:0] a, logic [2:0] size, int i);
    logic [63:0] step;
    int          lo, hi;
    logic [7:0]  s;
    step = 64'd1 << size;
    lo   = int'(a % 64'd8);
    if (i == 0) hi = int'(((a / step) * step) % 64'd8) + int'(step) - 1;
    else        hi = lo + int'(step) - 1;
    s = '0;
    for (int k = 0; k < SW; k++) if (k >= lo && k <= hi) s[k] = 1'b1;
    return s;
  endfunction

  function automatic bit model_legal(logic [63:0] a, logic [7:0] len, logic [2:0] size,
                                     logic [1:0] burst);
    logic [63:0] step, last;
    step = 64'd1 << size;
    if (step > 64'(SW)) return 1'b0;
    if (burst == 2'b11) return 1'b0;
    if (burst == 2'b10) begin
      if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) return 1'b0;
      if (a % step != 64'd0) return 1'b0;
    end
    if (burst == 2'b00 && len > 8'd15) return 1'b0;
    if (burst == 2'b01) begin
      last = (a / step) * step + (64'(len) + 64'd1) * step - 64'd1;
      if (a / 64'd4096 != last / 64'd4096) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Issues one request and follows it through every beat (or the error pulse).
  task automatic run_burst(input logic [63:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input bit legal, input bit rnd_stall);
    int i;
    int guard;
    bit rdy;
    @(negedge clk);
    check("req_ready_idle", 64'(req_ready_o), 64'd1);
    req_valid_i  = 1'b1;
    req_addr_i   = a;
    req_len_i    = len;
    req_size_i   = size;
    req_burst_i  = burst;
    beat_ready_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    if (!legal) begin
      check("err_pulse", 64'(err_o), 64'd1);
      check("err_no_valid", 64'(beat_valid_o), 64'd0);
      @(negedge clk);
      check("err_one_cycle", 64'(err_o), 64'd0);
      check("err_still_idle", 64'(beat_valid_o), 64'd0);
      return;
    end
    check("no_err", 64'(err_o), 64'd0);
    i     = 0;
    guard = 0;
    while (i <= int'(len) && guard < 400) begin
      check("beat_valid", 64'(beat_valid_o), 64'd1);
      check("beat_addr", beat_addr_o, exp_addr[i]);
      check("beat_strb", 64'(beat_strb_o), 64'(exp_strb[i]));
      check("beat_idx", 64'(beat_idx_o), 64'(i));
      check("beat_last", 64'(beat_last_o), 64'(i == int'(len)));
      rdy = rnd_stall ? ($urandom_range(3) != 0) : 1'b1;
      beat_ready_i = rdy;
      @(negedge clk);
      if (rdy) i++;
      guard++;
    end
    if (guard >= 400) check("burst_timeout", 64'd0, 64'd1);
    check("idle_after_burst", 64'(beat_valid_o), 64'd0);
    beat_ready_i = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs [4];
    logic [63:0] a;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    bit          lg;

    vecs[0] = '{64'h1003, 8'd2, 3'd2, 2'b01, 1'b1,
                {64'h0, 64'h1008, 64'h1004, 64'h1003}, {8'h00, 8'h0F, 8'hF0, 8'h08}};
    vecs[1] = '{64'h38, 8'd3, 3'd3, 2'b10, 1'b1,
                {64'h30, 64'h28, 64'h20, 64'h38}, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    vecs[2] = '{64'h102, 8'd3, 3'd1, 2'b00, 1'b1,
                {64'h102, 64'h102, 64'h102, 64'h102}, {8'h0C, 8'h0C, 8'h0C, 8'h0C}};
    vecs[3] = '{64'h40, 8'd2, 3'd3, 2'b10, 1'b0, '0, '0};

    rst_i        = 1'b1;
    req_valid_i  = 1'b0;
    req_addr_i   = '0;
    req_len_i    = '0;
    req_size_i   = '0;
    req_burst_i  = '0;
    beat_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 64'(beat_valid_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_addr", beat_addr_o, 64'd0);
    check("rst_strb", 64'(beat_strb_o), 64'd0);
    check("rst_idx", 64'(beat_idx_o), 64'd0);
    check("rst_last", 64'(beat_last_o), 64'd0);
    rst_i = 1'b0;

    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < 4; k++) begin
        exp_addr[k] = vecs[v].ea[k];
        exp_strb[k] = vecs[v].es[k];
      end
      run_burst(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, vecs[v].legal, 1'b0);
    end

    // Three-cycle stall on beat 1, then a new request on the last-beat handshake.
    @(negedge clk);
    req_valid_i = 1'b1; req_addr_i = 64'h200; req_len_i = 8'd3;
    req_size_i = 3'd3;  req_burst_i = 2'b01;  beat_ready_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    check("seq_b0_addr", beat_addr_o, 64'h200);
    check("seq_midburst_ready", 64'(req_ready_o), 64'd0);
    @(negedge clk);
    check("seq_b1_addr", beat_addr_o, 64'h208);
    beat_ready_i = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("hold_valid", 64'(beat_valid_o), 64'd1);
      check("hold_addr", beat_addr_o, 64'h208);
      check("hold_strb", 64'(beat_strb_o), 64'hFF);
      check("hold_idx", 64'(beat_idx_o), 64'd1);
      check("hold_last", 64'(beat_last_o), 64'd0);
      check("hold_ready", 64'(req_ready_o), 64'd0);
    end
    beat_ready_i = 1'b1;
    @(negedge clk);
    check("seq_b2_addr", beat_addr_o, 64'h210);
    @(negedge clk);
    check("seq_b3_addr", beat_addr_o, 64'h218);
    check("seq_b3_last", 64'(beat_last_o), 64'd1);
    check("seq_last_ready", 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1; req_addr_i = 64'h102; req_len_i = 8'd1;
    req_size_i = 3'd1;  req_burst_i = 2'b00;
    @(negedge clk);
    req_valid_i = 1'b0;
    check("b2b_valid", 64'(beat_valid_o), 64'd1);
    check("b2b_addr", beat_addr_o, 64'h102);
    check("b2b_strb", 64'(beat_strb_o), 64'h0C);
    check("b2b_idx", 64'(beat_idx_o), 64'd0);
    @(negedge clk);
    check("b2b_b1_last", 64'(beat_last_o), 64'd1);
    check("b2b_b1_idx", 64'(beat_idx_o), 64'd1);
    @(negedge clk);
    check("b2b_done", 64'(beat_valid_o), 64'd0);

    // Reset during beat 1 abandons the burst.
    req_valid_i = 1'b1; req_addr_i = 64'h400; req_len_i = 8'd3;
    req_size_i = 3'd3;  req_burst_i = 2'b01;
    @(negedge clk);
    req_valid_i = 1'b0;
    check("rb_b0_addr", beat_addr_o, 64'h400);
    @(negedge clk);
    check("rb_b1_idx", 64'(beat_idx_o), 64'd1);
    rst_i = 1'b1;
    @(negedge clk);
    check("rb_valid", 64'(beat_valid_o), 64'd0);
    check("rb_ready", 64'(req_ready_o), 64'd1);
    check("rb_addr", beat_addr_o, 64'd0);
    check("rb_idx", 64'(beat_idx_o), 64'd0);
    rst_i = 1'b0;
    @(negedge clk);
    check("rb_after_valid", 64'(beat_valid_o), 64'd0);
    check("rb_after_ready", 64'(req_ready_o), 64'd1);

    for (int n = 0; n < 150; n++) begin
      size  = ($urandom_range(9) == 0) ? 3'($urandom_range(7, 4)) : 3'($urandom_range(3));
      burst = ($urandom_range(7) == 0) ? 2'b11 : 2'($urandom_range(2));
      if (burst == 2'b10) begin
        case ($urandom_range(5))
          0: len = 8'd1;
          1: len = 8'd3;
          2: len = 8'd7;
          3: len = 8'd15;
          4: len = 8'd2;
          default: len = 8'd4;
        endcase
      end else begin
        len = 8'($urandom_range(15));
        if (burst == 2'b00 && $urandom_range(4) == 0) len = 8'($urandom_range(20, 16));
      end
      a = {32'h0, $urandom};
      if ($urandom_range(3) == 0) a = (a & ~64'hFFF) | 64'($urandom_range(4095, 4000));
      if (burst == 2'b10 && $urandom_range(1) == 0) a = a & ~((64'd1 << size) - 64'd1);
      lg = model_legal(a, len, size, burst);
      if (lg) begin
        for (int k = 0; k <= int'(len); k++) begin
          exp_addr[k] = model_addr(a, len, size, burst, k);
          exp_strb[k] = model_strb(exp_addr[k], size, k);
        end
      end
      run_burst(a, len, size, burst, lg, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
